// File: rtl/wrapper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wrapper_pkg : shared encodings for the IEEE 1500 wrapper controller   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wrapper_pkg;

  localparam int WS_BYPASS  = 0;
  localparam int WS_EXTEST  = 1;
  localparam int WS_INTEST  = 2;
  localparam int WS_PRELOAD = 3;

  // Low bits loaded into the WIR on Capture; upper bits are zero-filled.
  localparam logic [1:0] WIR_CAPTURE = 2'b01;

endpackage : wrapper_pkg
`default_nettype wire

// File: rtl/wir_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wir_reg : WIR shift stage and instruction (update) register           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wir_reg
  import wrapper_pkg::*;
#(
  parameter int WIR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic             wsi,
  output logic             wir_so,
  output logic [WIR_W-1:0] wir_instr
);

  logic [WIR_W-1:0] r_wir_sr;
  logic [WIR_W-1:0] r_wir_instr;

  // en already guarantees exactly one event is active this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wir_sr    <= '0;
      r_wir_instr <= '0;
    end else if (en) begin
      if (capture) begin
        r_wir_sr <= {{(WIR_W-2){1'b0}}, WIR_CAPTURE};
      end else if (shift) begin
        r_wir_sr <= {wsi, r_wir_sr[WIR_W-1:1]};
      end else if (update) begin
        r_wir_instr <= r_wir_sr;
      end
    end
  end

  assign wir_so    = r_wir_sr[0];
  assign wir_instr = r_wir_instr;

endmodule : wir_reg
`default_nettype wire

// File: rtl/wrapper_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wrapper_ctrl : WSP decode, WIR/WBY, WSO mux and boundary cell control |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wrapper_ctrl
  import wrapper_pkg::*;
#(
  parameter int WIR_W = 3
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             WSI,
  input  logic             SelectWIR,
  input  logic             CaptureWR,
  input  logic             ShiftWR,
  input  logic             UpdateWR,
  input  logic             wbr_so,
  output logic             WSO,
  output logic             wse_inputs,
  output logic             hold_inputs,
  output logic             wse_outputs,
  output logic             hold_outputs,
  output logic [WIR_W-1:0] wir_instr,
  output logic             wsp_err
);

  localparam logic [WIR_W-1:0] c_extest  = WIR_W'(WS_EXTEST);
  localparam logic [WIR_W-1:0] c_intest  = WIR_W'(WS_INTEST);
  localparam logic [WIR_W-1:0] c_preload = WIR_W'(WS_PRELOAD);

  logic [1:0] w_ev;
  logic       w_ev_one;
  logic       w_ev_ill;
  logic       w_wir_so;
  logic       w_is_extest;
  logic       w_is_intest;
  logic       w_is_preload;
  logic       w_wbr_sel;
  logic       w_d_ok;
  logic       w_wse;
  logic       r_wby;
  logic       r_wsp_err;

  assign w_ev     = {1'b0, CaptureWR} + {1'b0, ShiftWR} + {1'b0, UpdateWR};
  assign w_ev_one = (w_ev == 2'd1);
  assign w_ev_ill = (w_ev >= 2'd2);

  wir_reg #(
    .WIR_W (WIR_W)
  ) u_wir_reg (
    .clk       (CLK),
    .reset     (reset),
    .en        (SelectWIR & w_ev_one),
    .capture   (CaptureWR),
    .shift     (ShiftWR),
    .update    (UpdateWR),
    .wsi       (WSI),
    .wir_so    (w_wir_so),
    .wir_instr (wir_instr)
  );

  // Codes above PRELOAD fall through every compare and behave as BYPASS.
  assign w_is_extest  = (wir_instr == c_extest);
  assign w_is_intest  = (wir_instr == c_intest);
  assign w_is_preload = (wir_instr == c_preload);
  assign w_wbr_sel    = w_is_extest | w_is_intest | w_is_preload;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wby     <= 1'b0;
      r_wsp_err <= 1'b0;
    end else begin
      if (w_ev_ill) begin
        r_wsp_err <= 1'b1;
      end
      if (!SelectWIR && !w_wbr_sel && w_ev_one) begin
        if (CaptureWR) begin
          r_wby <= 1'b0;
        end else if (ShiftWR) begin
          r_wby <= WSI;
        end
      end
    end
  end

  assign WSO = SelectWIR ? w_wir_so : (w_wbr_sel ? wbr_so : r_wby);

  // Illegal combinations fail d_ok, which forces shift off and hold on.
  assign w_d_ok       = !SelectWIR && w_wbr_sel && w_ev_one;
  assign w_wse        = w_d_ok && ShiftWR;
  assign wse_inputs   = w_wse;
  assign wse_outputs  = w_wse;
  assign hold_inputs  = !(w_d_ok && CaptureWR && (w_is_extest || w_is_preload)) && !w_wse;
  assign hold_outputs = !(w_d_ok && CaptureWR && (w_is_intest || w_is_preload)) && !w_wse;
  assign wsp_err      = r_wsp_err;

endmodule : wrapper_ctrl
`default_nettype wire

// File: tb/tb_wrapper_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wrapper_ctrl : randomized + directed bench with a behavioural model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wrapper_ctrl;

  localparam int WIR_W = 3;

  logic             clk = 1'b0;
  logic             reset, wsi, sel, cap, shf, upd, wbr_so;
  logic             wso, wse_in, hold_in, wse_out, hold_out, err;
  logic [WIR_W-1:0] instr;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers manipulated arithmetically.
  int m_instr, m_sr, m_wby;
  bit m_err;
  // Expected combinational outputs for the currently driven inputs.
  bit e_wso, e_wse, e_hin, e_hout;

  always #5 clk = ~clk;

  wrapper_ctrl #(.WIR_W(WIR_W)) dut (
    .CLK(clk), .reset(reset), .WSI(wsi), .SelectWIR(sel),
    .CaptureWR(cap), .ShiftWR(shf), .UpdateWR(upd), .wbr_so(wbr_so),
    .WSO(wso), .wse_inputs(wse_in), .hold_inputs(hold_in),
    .wse_outputs(wse_out), .hold_outputs(hold_out),
    .wir_instr(instr), .wsp_err(err)
  );

  function automatic bit m_wbr(int i);
    return (i >= 1) && (i <= 3);
  endfunction

  function automatic void m_outputs();
    int  ev;
    bit  dok;
    ev     = int'(cap) + int'(shf) + int'(upd);
    dok    = !sel && m_wbr(m_instr) && (ev == 1);
    e_wse  = dok && shf;
    e_hin  = !(dok && cap && (m_instr == 1 || m_instr == 3)) && !e_wse;
    e_hout = !(dok && cap && (m_instr == 2 || m_instr == 3)) && !e_wse;
    e_wso  = sel ? bit'(m_sr & 1) : (m_wbr(m_instr) ? wbr_so : bit'(m_wby));
  endfunction

  function automatic void m_clock();
    int ev;
    ev = int'(cap) + int'(shf) + int'(upd);
    if (reset) begin
      m_instr = 0; m_sr = 0; m_wby = 0; m_err = 0;
    end else if (ev >= 2) begin
      m_err = 1;
    end else if (ev == 1) begin
      if (sel) begin
        if (cap)      m_sr = 1;
        else if (shf) m_sr = (m_sr >> 1) | (int'(wsi) << (WIR_W - 1));
        else          m_instr = m_sr;
      end else if (!m_wbr(m_instr)) begin
        if (cap)      m_wby = 0;
        else if (shf) m_wby = int'(wsi);
      end
    end
  endfunction

  // Apply inputs mid-cycle, settle, and compute model expectations.
  task automatic drive(input bit r, input bit s, input bit c, input bit sh,
                       input bit u, input bit d, input bit so);
    @(negedge clk);
    reset = r; sel = s; cap = c; shf = sh; upd = u; wsi = d; wbr_so = so;
    #1;
    m_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
  endtask

  task automatic load_wir(input int code);
    drive(0, 1, 1, 0, 0, 0, 0); tick();
    for (int i = 0; i < WIR_W; i++) begin
      drive(0, 1, 0, 1, 0, bit'((code >> i) & 1), 0); tick();
    end
    drive(0, 1, 0, 0, 1, 0, 0); tick();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (instr !== 3'd0 || wso !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state instr=%0d wso=%b err=%b, need 0/0/0", instr, wso, err);
    end
    checks++;
    if ({wse_in, wse_out, hold_in, hold_out} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_ctrl wse/hold=%b need 0011", {wse_in, wse_out, hold_in, hold_out});
    end
  endtask

  task automatic test_wir_load();
    bit exp_wso[3] = '{1'b1, 1'b0, 1'b0};
    drive(0, 1, 1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, (i == 0), 0);
      checks++;
      if (wso !== exp_wso[i]) begin
        errors++;
        $display("FAIL wir_shift_wso[%0d] got %b need %b", i, wso, exp_wso[i]);
      end
      tick();
    end
    drive(0, 1, 0, 0, 1, 0, 0);
    checks++;
    if (instr !== 3'd0) begin
      errors++;
      $display("FAIL wir_update_cycle instr=%0d need 0", instr);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (instr !== 3'd1) begin
      errors++;
      $display("FAIL wir_loaded instr=%0d need 1", instr);
    end
  endtask

  task automatic test_extest();
    bit so;
    drive(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (hold_in !== 1'b0 || hold_out !== 1'b1 || wse_in !== 1'b0) begin
      errors++;
      $display("FAIL extest_capture hold_in=%b hold_out=%b wse=%b need 0/1/0", hold_in, hold_out, wse_in);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      so = bit'($urandom_range(1));
      drive(0, 0, 0, 1, 0, bit'($urandom_range(1)), so);
      checks++;
      if (wse_in !== 1'b1 || wse_out !== 1'b1 || wso !== so || hold_in !== 1'b0 || hold_out !== 1'b0) begin
        errors++;
        $display("FAIL extest_shift[%0d] wse=%b%b hold=%b%b wso=%b need 11 00 %b", i, wse_in, wse_out, hold_in, hold_out, wso, so);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    bit din[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit dout[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    load_wir(0);
    drive(0, 0, 1, 0, 0, 1, 1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, din[i], ~dout[i]);
      checks++;
      if (wso !== dout[i] || wse_in !== 1'b0 || wse_out !== 1'b0) begin
        errors++;
        $display("FAIL bypass_shift[%0d] wso=%b wse=%b%b need %b 00", i, wso, wse_in, wse_out, dout[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    load_wir(2);
    drive(0, 0, 1, 1, 0, 1, 1);
    checks++;
    if ({wse_in, wse_out, hold_in, hold_out} !== 4'b0011 || err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_ctrl wse/hold=%b err=%b need 0011 0", {wse_in, wse_out, hold_in, hold_out}, err);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (err !== 1'b1 || instr !== 3'd2) begin
        errors++;
        $display("FAIL illegal_sticky[%0d] err=%b instr=%0d need 1 2", i, err, instr);
      end
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear err=%b need 0", err);
    end
  endtask

  task automatic test_reset_midshift();
    load_wir(3);
    drive(0, 1, 1, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 1, 0, 1, 0); tick();
    drive(0, 1, 0, 1, 0, 1, 0); tick();
    drive(1, 1, 0, 1, 0, 1, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (wso !== 1'b0 || instr !== 3'd0) begin
      errors++;
      $display("FAIL midshift_reset wso=%b instr=%0d need 0 0", wso, instr);
    end
    load_wir(3);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (instr !== 3'd3) begin
      errors++;
      $display("FAIL reload_after_reset instr=%0d need 3", instr);
    end
  endtask

  task automatic test_random();
    int  k;
    bit  c, s, u;
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(99));
      c = 0; s = 0; u = 0;
      if (k < 20)      c = 1;
      else if (k < 60) s = 1;
      else if (k < 75) u = 1;
      else if (k < 77) begin c = 1; u = 1; end
      drive(($urandom_range(199) == 0), ($urandom_range(3) == 0), c, s, u,
            bit'($urandom_range(1)), bit'($urandom_range(1)));
      checks++;
      if (wso !== e_wso || wse_in !== e_wse || wse_out !== e_wse ||
          hold_in !== e_hin || hold_out !== e_hout ||
          instr !== WIR_W'(m_instr) || err !== m_err) begin
        errors++;
        $display("FAIL random[%0d] wso=%b wse=%b%b hold=%b%b instr=%0d err=%b need %b %b%b %b%b %0d %b",
                 n, wso, wse_in, wse_out, hold_in, hold_out, instr, err,
                 e_wso, e_wse, e_wse, e_hin, e_hout, m_instr, m_err);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1; sel = 0; cap = 0; shf = 0; upd = 0; wsi = 0; wbr_so = 0;
    m_instr = 0; m_sr = 0; m_wby = 0; m_err = 0;
    test_reset();
    test_wir_load();
    test_extest();
    test_bypass();
    test_illegal();
    test_reset_midshift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule : tb_wrapper_ctrl
`default_nettype wire
